// File: rtl/fwd_mux_pipe.sv
// rtl/fwd_mux_pipe.sv - N-way operand forwarding mux with registered output stage
// Illegal selects hold dout, pulse sel_err and bump a saturating error counter.
module fwd_mux_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    clr_err,
  output logic [WIDTH-1:0]        dout,
  output logic                    out_valid,
  output logic                    sel_err,
  output logic [CNT_W-1:0]        err_cnt
);

  // One extra bit so NUM_IN == 2**SEL_W is representable.
  localparam logic [SEL_W:0] NUM_IN_L = (SEL_W+1)'(NUM_IN);

  logic             legal;
  logic             accept;
  logic             bump;
  logic [WIDTH-1:0] sel_data;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) sel_data = din[k*WIDTH +: WIDTH];
    end
  end

  assign legal  = ({1'b0, sel} < NUM_IN_L);
  assign accept = in_valid & ~stall & ~flush;
  assign bump   = accept & ~legal & (err_cnt != '1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout      <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (flush) begin
        dout      <= '0;
        out_valid <= 1'b0;
        sel_err   <= 1'b0;
      end else if (!stall) begin
        if (in_valid && legal) begin
          dout      <= sel_data;
          out_valid <= 1'b1;
          sel_err   <= 1'b0;
        end else begin
          out_valid <= 1'b0;
          sel_err   <= in_valid;
        end
      end
      // Clear beats a same-cycle increment.
      if (clr_err) err_cnt <= '0;
      else if (bump) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_mux_pipe.sv
// tb/tb_fwd_mux_pipe.sv - scoreboard bench for fwd_mux_pipe (3x32 CNT_W=2 and 4x8 instances)
module tb_fwd_mux_pipe;

  typedef struct {
    logic [31:0] dout;
    bit          valid;
    bit          err;
    int          cnt;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sel = '0;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        clr_err = 1'b0;
  logic [31:0] wa [3];
  logic [7:0]  wb [4];
  logic [95:0] din_a;
  logic [31:0] din_b;
  logic [31:0] dout_a;
  logic [7:0]  dout_b;
  logic        out_valid_a, out_valid_b, sel_err_a, sel_err_b;
  logic [1:0]  err_cnt_a;
  logic [7:0]  err_cnt_b;

  int    checks = 0;
  int    errors = 0;
  pair_t q[$];
  exp_t  ma, mb;

  assign din_a = {wa[2], wa[1], wa[0]};
  assign din_b = {wb[3], wb[2], wb[1], wb[0]};

  always #5 clk = ~clk;

  fwd_mux_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .clr_err(clr_err), .dout(dout_a),
    .out_valid(out_valid_a), .sel_err(sel_err_a), .err_cnt(err_cnt_a));

  fwd_mux_pipe #(.WIDTH(8), .NUM_IN(4), .SEL_W(2), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .clr_err(clr_err), .dout(dout_b),
    .out_valid(out_valid_b), .sel_err(sel_err_b), .err_cnt(err_cnt_b));

  // Reference: next observable state of a forwarding stage from the rules alone.
  function automatic exp_t step(exp_t s, bit r, bit iv, bit st, bit fl, bit cl,
                                int sv, int n, int mx, logic [31:0] d);
    exp_t o = s;
    if (!r) begin
      o = '{32'h0, 1'b0, 1'b0, 0};
      return o;
    end
    if (fl) begin
      o.dout = 32'h0; o.valid = 1'b0; o.err = 1'b0;
    end else if (!st) begin
      if (iv && sv < n) begin
        o.dout = d; o.valid = 1'b1; o.err = 1'b0;
      end else if (iv) begin
        o.valid = 1'b0; o.err = 1'b1;
        if (o.cnt < mx) o.cnt = o.cnt + 1;
      end else begin
        o.valid = 1'b0; o.err = 1'b0;
      end
    end
    if (cl) o.cnt = 0;
    return o;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc(bit r, bit iv, int s, bit st, bit fl, bit cl);
    pair_t p;
    logic [31:0] da, db;
    rst_n = r; in_valid = iv; sel = s[1:0]; stall = st; flush = fl; clr_err = cl;
    da = (s < 3) ? wa[s] : 32'h0;
    db = {24'h0, wb[s]};
    ma = step(ma, r, iv, st, fl, cl, s, 3, 3, da);
    mb = step(mb, r, iv, st, fl, cl, s, 4, 255, db);
    p.a = ma;
    p.b = mb;
    q.push_back(p);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin : monitor
    pair_t p;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        p = q.pop_front();
        chk("a_dout",      dout_a,                 p.a.dout);
        chk("a_out_valid", {31'h0, out_valid_a},   {31'h0, p.a.valid});
        chk("a_sel_err",   {31'h0, sel_err_a},     {31'h0, p.a.err});
        chk("a_err_cnt",   {30'h0, err_cnt_a},     p.a.cnt);
        chk("b_dout",      {24'h0, dout_b},        p.b.dout);
        chk("b_out_valid", {31'h0, out_valid_b},   {31'h0, p.b.valid});
        chk("b_sel_err",   {31'h0, sel_err_b},     {31'h0, p.b.err});
        chk("b_err_cnt",   {24'h0, err_cnt_b},     p.b.cnt);
      end
    end
  end

  initial begin : stim
    int budget;
    ma = '{32'h0, 1'b0, 1'b0, 0};
    mb = '{32'h0, 1'b0, 1'b0, 0};
    wa[0] = 32'h11111111; wa[1] = 32'h22222222; wa[2] = 32'h33333333;
    for (int k = 0; k < 4; k++) wb[k] = 8'hA0 + 8'(k);
    #1;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 2, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 2, 0, 0, 0);
    cyc(1, 1, 3, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 3, 1, 0, 0);
    cyc(1, 1, 3, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 1, 3, 0, 0, 0);
    cyc(1, 1, 3, 0, 0, 1);
    for (int s = 0; s < 4; s++) cyc(1, 1, s, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(0, 1, 2, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < 3; k++) wa[k] = $urandom;
      for (int k = 0; k < 4; k++) wb[k] = 8'($urandom);
      cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0));
    end
    cyc(1, 0, 0, 0, 0, 0);
    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 entries left", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
